fdivsqrt_arb: RTL

Arbiter and sequencer that shares the single iterative divide/square-root unit between two requesters: the integer divider path (MDU) and the floating-point divide/sqrt path (FPU). It grants one request at a time with round-robin fairness, issues a start pulse and cycle budget to the unit, counts iterations, and returns a tagged completion that is held until the owning requester accepts it. Either requester can flush its own in-flight operation. The block sits between the execute-stage issue logic and the divsqrt datapath.

---
 rtl/fdivsqrt_arb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fdivsqrt_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fdivsqrt_arb
//  Description : Shares one iterative divide/sqrt unit between the integer
//                divide path and the FP divide/sqrt path. Round-robin grant,
//                start pulse + iteration budget, tagged completion held until
//                accepted, per-owner flush with abort pulse.
//                Optional integer path: define FDIVSQRT_ARB_IDIV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fdivsqrt_arb #(
    parameter int DURLEN = 6,
    parameter int TAGW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IReqValid,
    output logic              IReqReady,
    input  logic [DURLEN-1:0] IReqCycles,
    input  logic [TAGW-1:0]   IReqTag,
    input  logic              FReqValid,
    output logic              FReqReady,
    input  logic [DURLEN-1:0] FReqCycles,
    input  logic [TAGW-1:0]   FReqTag,
    input  logic              FlushI,
    input  logic              FlushF,
    output logic              UnitStart,
    output logic              UnitIntDiv,
    output logic              UnitAbort,
    input  logic              UnitDone,
    output logic              RspValid,
    output logic              RspIsInt,
    output logic [TAGW-1:0]   RspTag,
    input  logic              RspReady,
    output logic              Busy
);

    localparam logic [DURLEN-1:0] c_one = DURLEN'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    logic [DURLEN-1:0] r_count;
    logic [TAGW-1:0]   r_tag;

    logic              w_idle;
    logic              w_hold;
    logic              w_acc_int;
    logic              w_acc_fp;
    logic              w_accept;
    logic              w_owner_int;
    logic              w_owner_flush;
    logic [DURLEN-1:0] w_req_cycles;
    logic [DURLEN-1:0] w_load_cycles;
    logic [TAGW-1:0]   w_req_tag;

    assign w_idle = (r_state == S_IDLE);
    assign w_hold = (r_state == S_HOLD);

`ifdef FDIVSQRT_ARB_IDIV_EN
    logic r_last_int;
    logic r_owner_int;
    logic w_grant_int;
    logic w_grant_fp;

    // Round robin: on a tie the requester not granted last wins.
    assign w_grant_int   = IReqValid & (~FReqValid | ~r_last_int);
    assign w_grant_fp    = FReqValid & (~IReqValid |  r_last_int);
    assign w_acc_int     = w_idle & w_grant_int & ~FlushI;
    assign w_acc_fp      = w_idle & w_grant_fp  & ~FlushF;
    assign w_owner_int   = r_owner_int;
    assign w_owner_flush = ~w_idle & (r_owner_int ? FlushI : FlushF);
    assign w_req_cycles  = w_acc_int ? IReqCycles : FReqCycles;
    assign w_req_tag     = w_acc_int ? IReqTag    : FReqTag;
`else
    // Integer division lives in the MDU: FP is the only requester.
    logic w_unused_idiv;
    assign w_unused_idiv = ^{IReqValid, IReqCycles, IReqTag, FlushI};
    assign w_acc_int     = 1'b0;
    assign w_acc_fp      = w_idle & FReqValid & ~FlushF;
    assign w_owner_int   = 1'b0;
    assign w_owner_flush = ~w_idle & FlushF;
    assign w_req_cycles  = FReqCycles;
    assign w_req_tag     = FReqTag;
`endif

    assign w_accept      = w_acc_int | w_acc_fp;
    // A zero budget would never terminate; run at least one iteration.
    assign w_load_cycles = (w_req_cycles == '0) ? c_one : w_req_cycles;

    // Sequencer: accept in IDLE, count iterations in RUN, hold response in HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_tag       <= '0;
`ifdef FDIVSQRT_ARB_IDIV_EN
            r_last_int  <= 1'b0;
            r_owner_int <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_RUN;
                        r_count     <= w_load_cycles;
                        r_tag       <= w_req_tag;
`ifdef FDIVSQRT_ARB_IDIV_EN
                        r_owner_int <= w_acc_int;
                        r_last_int  <= w_acc_int;
`endif
                    end
                end
                S_RUN: begin
                    // Owner flush outranks both normal and early completion.
                    if (w_owner_flush) begin
                        r_state <= S_IDLE;
                    end else if ((r_count == c_one) || UnitDone) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_count <= r_count - c_one;
                    end
                end
                S_HOLD: begin
                    // A flush here means the response was never delivered.
                    if (w_owner_flush || RspReady) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign IReqReady  = w_acc_int;
    assign FReqReady  = w_acc_fp;
    assign UnitStart  = w_accept;
    assign UnitIntDiv = w_acc_int;
    assign UnitAbort  = w_owner_flush;
    assign RspValid   = w_hold;
    assign RspIsInt   = w_hold & w_owner_int;
    assign RspTag     = w_hold ? r_tag : '0;
    assign Busy       = ~w_idle;

endmodule
`default_nettype wire
